shot_eval: RTL
==============

# shot_eval

Shot evaluator for the target game: launches a projectile from the cannon column on `shoot`, steps it up the 32-row playfield at a fixed rate, and judges hit/miss against the current `target_x`/`target_y`. It is the consumer of the target generator's coordinates. It produces the `result_valid` pulse that advances the target generator's RNG. It also keeps the score and shot budget for one game.

## Interface
- `STEP_DIV`, 4: clock cycles per projectile row step; legal range 1..255.
- `SHOTS`, 10: shots per game; legal range 1..15.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: clock enable. When low, every register holds.
- `start_new_game` in 1: restart the game and abort any flight.
- `shoot` in 1: fire request. Level-sampled in IDLE only.
- `cannon_x` in 5: cannon column. Sampled at launch only.
- `target_x` in 5: target column. Sampled live at each step tick.
- `target_y` in 5: target row. Sampled live at each step tick.
- `result_valid` out 1: one-cycle pulse when a shot is judged.
- `hit` out 1: verdict of the last judged shot. Held until the next launch.
- `proj_active` out 1: projectile in flight.
- `proj_x` out 5: projectile column.
- `proj_y` out 5: projectile row (0 = cannon row).
- `score` out 8: hit count. Saturates at 255.
- `shots_left` out 4: remaining shots.
- `game_over` out 1: high once all shots are judged.

## Operation
- Reset (`rst_n`=0, asynchronous) sets:
  - state IDLE;
  - `result_valid`=0, `hit`=0, `proj_active`=0;
  - `proj_x`=0, `proj_y`=0;
  - `score`=0, `shots_left`=SHOTS, `game_over`=0;
  - step counter = 0.
- All updates below happen on a rising `clk` edge with `ena`=1. When `ena`=0 nothing changes, including a pending `result_valid`.
- `start_new_game`=1 has highest priority, in any state:
  - it applies the reset values, except `proj_x`/`proj_y`, which hold;
  - state goes to IDLE, and any flight is aborted with no result pulse;
  - `shoot` is ignored on that edge.
- IDLE state:
  - Launch occurs when `shoot`=1, `shots_left`≠0 and `game_over`=0.
  - On launch: `proj_x`←`cannon_x`, `proj_y`←0, step counter←0, `proj_active`←1, `hit`←0, `shots_left`←`shots_left`−1. State goes to FLIGHT.
  - Otherwise the state holds.
- FLIGHT state:
  - The step counter increments every cycle.
  - A step tick is the edge on which the counter equals STEP_DIV−1. On a tick the counter returns to 0, then:
    - if `proj_y`==`target_y`: judge with `hit`←(`proj_x`==`target_x`);
    - else if `proj_y`==31: judge as a miss, `hit`←0;
    - else `proj_y`←`proj_y`+1. No wrap is possible.
  - Judging (on the same edge): `result_valid`←1, `proj_active`←0, `score`←`score`+`hit` (saturating at 255). State goes to RESULT.
  - `shoot` is ignored during flight.
- RESULT state (exactly one cycle):
  - `result_valid`←0.
  - `game_over`←1 if `shots_left`==0.
  - State goes to IDLE. `shoot` is ignored.
- `proj_x`/`proj_y` hold their final values after judging, until the next launch.
- If the target coordinates change mid-flight, the value present at each tick is the one used.

## Timing
- Launch is sampled at edge 0, and `proj_active`=1 after edge 0.
- Tick k occurs at edge STEP_DIV·(k+1), evaluating `proj_y`=k.
- For a target on row T, `result_valid` goes high after edge STEP_DIV·(T+1) and low after the following edge.
- For STEP_DIV=4, T=30: the pulse follows edge 124.
- The next launch is possible at the second edge after the pulse edge, i.e. the first IDLE edge.
- `game_over` rises one edge after the final `result_valid` pulse.
- With STEP_DIV=1, every FLIGHT edge is a tick.

## Test plan
- **Hit.** Reset, STEP_DIV=4, target (12,30), `cannon_x`=12, `shoot` at edge 0.
  - `proj_y` steps 0..30.
  - Single `result_valid` pulse after edge 124 with `hit`=1.
  - `score`=1, `shots_left`=9.
- **Miss.** Same setup with `cannon_x`=5.
  - Pulse after edge 124 with `hit`=0, `score`=0.
  - Target (5,31): pulse after edge 128 with `hit`=1.
- **Budget exhaustion.** Fire 10 shots back-to-back with `shoot` held high.
  - Exactly 10 pulses; `shots_left`=0.
  - `game_over`=1 one edge after the 10th pulse.
  - Further shots are ignored.
  - `start_new_game` restores `shots_left`=10 and `score`=0.
- **Abort and `ena` freeze.**
  - `start_new_game` at edge 50 of a flight: `proj_active`→0 and no pulse ever appears.
  - `ena`=0 for 20 cycles mid-flight: the pulse is delayed by exactly 20 edges.
- **Async reset mid-flight.** Drive `rst_n` low between clock edges.
  - All outputs take reset values immediately, with no clock edge required.
  - After release, `shots_left`=SHOTS.
- **Score saturation.** Force `score` to 255 via a bench preload, or run 26 games with a carried score.
  - Another hit keeps `score`=255.

Source files
------------

// File: rtl/shot_eval_if.sv
// Bus bundle between the shot evaluator and its environment: game controls,
// target coordinates in, projectile/score status out.
interface shot_eval_if;
    logic       start_new_game;
    logic       shoot;
    logic [4:0] cannon_x;
    logic [4:0] target_x;
    logic [4:0] target_y;
    logic       result_valid;
    logic       hit;
    logic       proj_active;
    logic [4:0] proj_x;
    logic [4:0] proj_y;
    logic [7:0] score;
    logic [3:0] shots_left;
    logic       game_over;

    modport slave (
        input  start_new_game, shoot, cannon_x, target_x, target_y,
        output result_valid, hit, proj_active, proj_x, proj_y,
               score, shots_left, game_over
    );

    modport master (
        output start_new_game, shoot, cannon_x, target_x, target_y,
        input  result_valid, hit, proj_active, proj_x, proj_y,
               score, shots_left, game_over
    );
endinterface

// File: rtl/shot_eval.sv
// Shot evaluator: launches a projectile up a 32-row playfield, judges hit/miss
// against the live target, and tracks score and shot budget for one game.
module shot_eval #(
    parameter int STEP_DIV = 4,
    parameter int SHOTS    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    shot_eval_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLIGHT = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam logic [7:0] STEP_LAST  = 8'(STEP_DIV - 1);
    localparam logic [3:0] SHOTS_INIT = 4'(SHOTS);

    state_t     state_q, state_d;
    logic [7:0] step_cnt_q, step_cnt_d;
    logic       result_valid_q, result_valid_d;
    logic       hit_q, hit_d;
    logic       proj_active_q, proj_active_d;
    logic [4:0] proj_x_q, proj_x_d;
    logic [4:0] proj_y_q, proj_y_d;
    logic [7:0] score_q, score_d;
    logic [3:0] shots_left_q, shots_left_d;
    logic       game_over_q, game_over_d;
    logic       judge_s;
    logic       verdict_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        if (inc && (v != 8'hFF)) begin
            return v + 8'd1;
        end else begin
            return v;
        end
    endfunction

    // Next-state and datapath decode; start_new_game overrides every state.
    always_comb begin
        state_d        = state_q;
        step_cnt_d     = step_cnt_q;
        result_valid_d = result_valid_q;
        hit_d          = hit_q;
        proj_active_d  = proj_active_q;
        proj_x_d       = proj_x_q;
        proj_y_d       = proj_y_q;
        score_d        = score_q;
        shots_left_d   = shots_left_q;
        game_over_d    = game_over_q;
        judge_s        = 1'b0;
        verdict_s      = 1'b0;

        if (bus.start_new_game) begin
            state_d        = ST_IDLE;
            step_cnt_d     = 8'd0;
            result_valid_d = 1'b0;
            hit_d          = 1'b0;
            proj_active_d  = 1'b0;
            score_d        = 8'd0;
            shots_left_d   = SHOTS_INIT;
            game_over_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.shoot && (shots_left_q != 4'd0) && !game_over_q) begin
                        proj_x_d      = bus.cannon_x;
                        proj_y_d      = 5'd0;
                        step_cnt_d    = 8'd0;
                        proj_active_d = 1'b1;
                        hit_d         = 1'b0;
                        shots_left_d  = shots_left_q - 4'd1;
                        state_d       = ST_FLIGHT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FLIGHT: begin
                    if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = 8'd0;
                        if (proj_y_q == bus.target_y) begin
                            judge_s   = 1'b1;
                            verdict_s = (proj_x_q == bus.target_x);
                        end else if (proj_y_q == 5'd31) begin
                            judge_s   = 1'b1;
                            verdict_s = 1'b0;
                        end else begin
                            proj_y_d = proj_y_q + 5'd1;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 8'd1;
                    end
                    // The verdict and score update land on the judging edge itself.
                    if (judge_s) begin
                        hit_d          = verdict_s;
                        result_valid_d = 1'b1;
                        proj_active_d  = 1'b0;
                        score_d        = sat_inc(score_q, verdict_s);
                        state_d        = ST_RESULT;
                    end else begin
                        state_d = ST_FLIGHT;
                    end
                end
                ST_RESULT: begin
                    result_valid_d = 1'b0;
                    if (shots_left_q == 4'd0) begin
                        game_over_d = 1'b1;
                    end else begin
                        game_over_d = game_over_q;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            step_cnt_q     <= 8'd0;
            result_valid_q <= 1'b0;
            hit_q          <= 1'b0;
            proj_active_q  <= 1'b0;
            proj_x_q       <= 5'd0;
            proj_y_q       <= 5'd0;
            score_q        <= 8'd0;
            shots_left_q   <= SHOTS_INIT;
            game_over_q    <= 1'b0;
        end else if (ena) begin
            state_q        <= state_d;
            step_cnt_q     <= step_cnt_d;
            result_valid_q <= result_valid_d;
            hit_q          <= hit_d;
            proj_active_q  <= proj_active_d;
            proj_x_q       <= proj_x_d;
            proj_y_q       <= proj_y_d;
            score_q        <= score_d;
            shots_left_q   <= shots_left_d;
            game_over_q    <= game_over_d;
        end
    end

    assign bus.result_valid = result_valid_q;
    assign bus.hit          = hit_q;
    assign bus.proj_active  = proj_active_q;
    assign bus.proj_x       = proj_x_q;
    assign bus.proj_y       = proj_y_q;
    assign bus.score        = score_q;
    assign bus.shots_left   = shots_left_q;
    assign bus.game_over    = game_over_q;

endmodule
